// File: rtl/pe_edge_feeder.sv
// pe_edge_feeder: per-lane operand buffers streamed into the west/north edge
// of the PE array with diagonal skew (lane i delayed i cycles) and global
// back-pressure from the edge PE full flags.
// Optional build macro: FEEDER_ZERO_PAD_EN (every lane writes on every
// non-stalled STREAM cycle, sending 0 outside its window).
module pe_edge_feeder #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [((LANES>1)?$clog2(LANES):1)-1:0] wr_lane,
  input  logic [DW-1:0]                     wr_data,
  input  logic [7:0]                        len,
  input  logic                              go,
  input  logic [LANES-1:0]                  pe_full,
  output logic                              start_out,
  output logic [LANES*DW-1:0]               vec_out,
  output logic [LANES-1:0]                  vwe,
  output logic [7:0]                        max_cntr,
  output logic                              busy,
  output logic                              done,
  output logic                              go_err,
  output logic                              ovf
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = 16;

  typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     mem    [LANES][DEPTH];
  logic [AW-1:0]     wr_ptr [LANES];
  logic [AW-1:0]     rd_ptr [LANES];
  logic [CW-1:0]     cnt    [LANES];
  logic [LANES-1:0]  push;
  logic [LANES-1:0]  pop;
  logic [TW-1:0]     t;
  logic              stall;
  logic              go_ok;
  logic              last_issue;
  logic              wr_full;

  // Run admission: len in 1..DEPTH and every lane already holds len entries
  always_comb begin
    go_ok = (len != 8'd0) && (int'(len) <= int'(DEPTH));
    for (int unsigned i = 0; i < LANES; i++) begin
      if (int'(cnt[i]) < int'(len)) go_ok = 1'b0;
    end
  end

  // Host write decode; a write to a full lane is dropped
  always_comb begin
    push    = '0;
    wr_full = wr_en && (cnt[wr_lane] == CW'(DEPTH));
    for (int unsigned i = 0; i < LANES; i++) begin
      push[i] = wr_en && (wr_lane == LW'(i)) && (cnt[i] != CW'(DEPTH));
    end
  end

  // Skewed issue: lane i carries element t-i while i <= t < i+len
  always_comb begin
    stall   = |pe_full;
    vwe     = '0;
    vec_out = '0;
    pop     = '0;
    if (state == S_STREAM) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if ((t >= TW'(i)) && (t < TW'(i) + TW'(max_cntr))) begin
          vec_out[i*DW +: DW] = mem[i][rd_ptr[i]];
          pop[i]              = !stall;
          vwe[i]              = !stall;
        end
`ifdef FEEDER_ZERO_PAD_EN
        vwe[i] = !stall;
`endif
      end
    end
    last_issue = (state == S_STREAM) && !stall &&
                 (t == TW'(max_cntr) + TW'(LANES) - TW'(2));
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (go && go_ok) state_nxt = S_START;
      S_START:  state_nxt = S_STREAM;
      S_STREAM: if (last_issue) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    start_out = (state == S_START);
    busy      = (state == S_START) || (state == S_STREAM);
    done      = (state == S_DONE);
  end

  // Control registers: state, stream counter, latched length, status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      t        <= '0;
      max_cntr <= '0;
      go_err   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state  <= state_nxt;
      go_err <= go && (state == S_IDLE) && !go_ok;
      if (wr_full) ovf <= 1'b1;
      if ((state == S_IDLE) && go && go_ok) max_cntr <= len;
      if (state == S_START) t <= '0;
      else if ((state == S_STREAM) && !stall) t <= t + TW'(1);
    end
  end

  // Per-lane pointers and occupancy; simultaneous push and pop cancel
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (rst) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Buffer storage, contents are don't-care while the lane is empty
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_pe_edge_feeder.sv
// Self-checking bench for pe_edge_feeder: queue-based reference model compared
// every cycle, plus literal latency/data pins for the directed scenarios.
module tb_pe_edge_feeder;
  localparam int LANES = 4;
  localparam int DEPTH = 16;
  localparam int DW    = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  wr_en = 1'b0;
  logic [1:0]            wr_lane = '0;
  logic [DW-1:0]         wr_data = '0;
  logic [7:0]            len = '0;
  logic                  go = 1'b0;
  logic [LANES-1:0]      pe_full = '0;
  logic                  start_out, busy, done, go_err, ovf;
  logic [LANES*DW-1:0]   vec_out;
  logic [LANES-1:0]      vwe;
  logic [7:0]            max_cntr;

  pe_edge_feeder #(.LANES(LANES), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_lane(wr_lane), .wr_data(wr_data),
    .len(len), .go(go), .pe_full(pe_full), .start_out(start_out),
    .vec_out(vec_out), .vwe(vwe), .max_cntr(max_cntr), .busy(busy),
    .done(done), .go_err(go_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  bit armed = 0;

  always @(posedge clk) begin
    cyc_cnt++;
    if (rst) armed = 1;
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc_cnt);
    end
  endtask

  // Reference model: lane FIFOs as queues, a run described by the cycles since
  // acceptance and the number of unstalled issue steps taken so far.
  typedef logic [DW-1:0] dq_t[$];
  dq_t q [LANES];
  bit  in_run = 0;
  int  since = 0, t = 0, L = 0;
  bit  m_ovf = 0, m_gerr = 0;
  logic [7:0] m_mx = '0;

  // Event captures for the literal pins
  int start_cyc = -1, v0_cyc = -1, v1_cyc = -1, done_cyc = -1, gerr_cyc = -1, v3_n = 0;
  logic [DW-1:0] v0_dat = '0;

  always @(negedge clk) begin
    bit stall, strm, dn, accept, full, ok;
    bit act [LANES];
    logic [LANES-1:0] e_vwe;
    logic [LANES*DW-1:0] e_vec;
    stall = |pe_full;
    strm  = in_run && since >= 2 && t < L + LANES - 1;
    dn    = in_run && since >= 2 && t == L + LANES - 1;
    e_vwe = '0;
    e_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      act[i] = strm && t >= i && t < i + L;
      if (act[i]) begin
        e_vec[i*DW +: DW] = q[i][0];
        e_vwe[i] = !stall;
      end
`ifdef FEEDER_ZERO_PAD_EN
      if (strm) e_vwe[i] = !stall;
`endif
    end
    if (armed) begin
      chk("start_out", start_out, in_run && since == 1);
      chk("busy", busy, in_run && !dn);
      chk("done", done, dn);
      chk("go_err", go_err, m_gerr);
      chk("ovf", ovf, m_ovf);
      chk("max_cntr", max_cntr, m_mx);
      chk("vwe", vwe, e_vwe);
      chk("vec_out", vec_out, e_vec);
      if (start_out && start_cyc < 0) start_cyc = cyc_cnt;
      if (vwe[0] && v0_cyc < 0) begin v0_cyc = cyc_cnt; v0_dat = vec_out[DW-1:0]; end
      if (vwe[1] && v1_cyc < 0) v1_cyc = cyc_cnt;
      if (vwe[3]) v3_n++;
      if (done && done_cyc < 0) done_cyc = cyc_cnt;
      if (go_err && gerr_cyc < 0) gerr_cyc = cyc_cnt;
    end
    // advance model to the next cycle
    if (rst) begin
      for (int i = 0; i < LANES; i++) q[i].delete();
      in_run = 0; m_ovf = 0; m_gerr = 0; m_mx = '0; since = 0; t = 0;
    end else begin
      full = wr_en && q[wr_lane].size() == DEPTH;
      ok = go && !in_run && len >= 1 && len <= DEPTH;
      for (int i = 0; i < LANES; i++) if (q[i].size() < len) ok = 0;
      accept = ok;
      m_gerr = go && !in_run && !accept;
      if (strm && !stall) begin
        for (int i = 0; i < LANES; i++) if (act[i]) void'(q[i].pop_front());
        t++;
      end
      if (wr_en) begin
        if (full) m_ovf = 1;
        else q[wr_lane].push_back(wr_data);
      end
      if (in_run) begin
        if (dn) in_run = 0;
        else if (since < 2) since++;
      end
      if (accept) begin
        in_run = 1; since = 1; t = 0; L = len; m_mx = len;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int lane, input logic [DW-1:0] d);
    wr_en = 1; wr_lane = 2'(lane); wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic clr_caps();
    start_cyc = -1; v0_cyc = -1; v1_cyc = -1; done_cyc = -1; gerr_cyc = -1; v3_n = 0;
  endtask

  task automatic fill_basic();
    wr(0, -16'sd1); wr(0, -16'sd2); wr(0, 16'sd2); wr(0, -16'sd2);
    wr(1, -16'sd2); wr(1, 16'sd3); wr(1, -16'sd5); wr(1, -16'sd5);
    for (int l = 2; l < LANES; l++)
      for (int k = 0; k < 4; k++) wr(l, 16'($urandom));
  endtask

  task automatic do_go(input int n_len, output int n);
    clr_caps();
    n = cyc_cnt; go = 1; len = 8'(n_len);
    tick();
    go = 0;
  endtask

  initial begin
    int n;
    // reset with go held high
    go = 1; len = 8'd1; rst = 1;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", start_out, 0);
    rst = 0; go = 0;
    tick();

    // basic run
    fill_basic();
    do_go(4, n);
    repeat (12) tick();
    chk("basic_start_lat", start_cyc, n + 1);
    chk("basic_v0_lat", v0_cyc, n + 2);
    chk("basic_v0_data", v0_dat, 16'hFFFF);
    chk("basic_v1_lat", v1_cyc, n + 3);
    chk("basic_done_lat", done_cyc, n + 9);
    chk("basic_max_cntr", max_cntr, 8'd4);

    // back-pressure: three stalled cycles mid-stream
    fill_basic();
    do_go(4, n);
    repeat (3) tick();
    pe_full = 4'b0100;
    repeat (3) tick();
    pe_full = '0;
    repeat (10) tick();
    chk("bp_done_lat", done_cyc, n + 12);

    // rejects
    fill_basic();
    do_go(5, n);
    tick();
    chk("rej_len5_lat", gerr_cyc, n + 1);
    do_go(0, n);
    tick();
    chk("rej_len0_lat", gerr_cyc, n + 1);
    do_go(4, n);   // drain with an accepted run
    repeat (12) tick();

    // overflow: 17 writes to lane0, then fill the rest and drain 16
    for (int k = 0; k < 17; k++) wr(0, 16'(k));
    tick();
    chk("ovf_set", ovf, 1);
    for (int l = 1; l < LANES; l++)
      for (int k = 0; k < 16; k++) wr(l, 16'($urandom));
    do_go(16, n);
    repeat (24) tick();
    do_go(1, n);
    tick(); tick();

    // concurrent writes to lane0 during stream
    rst = 1; tick(); rst = 0;
    fill_basic();
    do_go(4, n);
    repeat (2) tick();
    for (int k = 0; k < 3; k++) wr(0, 16'(100 + k));
    repeat (10) tick();
    for (int l = 1; l < LANES; l++)
      for (int k = 0; k < 3; k++) wr(l, 16'($urandom));
    do_go(3, n);
    repeat (10) tick();
    chk("conc_done_lat", done_cyc, n + 8);

    // abort mid-stream
    fill_basic();
    do_go(4, n);
    repeat (4) tick();
    rst = 1; tick(); rst = 0;
    repeat (8) tick();
    chk("abort_no_done", done_cyc, -1);
    do_go(1, n);
    tick(); tick();

    // lane3 write count with len=2
    for (int l = 0; l < LANES; l++) begin wr(l, 16'(7 + l)); wr(l, 16'(9 + l)); end
    do_go(2, n);
    repeat (10) tick();
`ifdef FEEDER_ZERO_PAD_EN
    chk("lane3_writes", v3_n, 5);
`else
    chk("lane3_writes", v3_n, 2);
`endif

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      wr_en   = ($urandom % 2) == 0;
      wr_lane = 2'($urandom % LANES);
      wr_data = 16'($urandom);
      pe_full = (($urandom % 6) == 0) ? 4'($urandom) : 4'b0;
      go      = ($urandom % 12) == 0;
      len     = 8'($urandom_range(0, 6));
      rst     = ($urandom % 300) == 0;
      tick();
    end
    wr_en = 0; go = 0; pe_full = '0; rst = 0;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/pe_edge_feeder.md
Name: pe_edge_feeder

Overview:
- Upstream feeder for the west/north edge of the systolic PE array.
- Buffers per-lane operand vectors written by the host, then on command issues one start pulse and streams each lane into its edge PE (a_in/awe or b_in/bwe) with diagonal skew: lane i is delayed i cycles.
- Honours the PE input-FIFO full flags (aff/bff) with global back-pressure.
- Drives max_cntr to the array.

Parameters:
- LANES, 4, number of edge PEs fed (one lane each)
- DEPTH, 16, entries per lane buffer (power of two)
- DW, 16, operand width, signed two's complement

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  host write strobe
- wr_lane  in  $clog2(LANES)  target lane for wr_data
- wr_data  in  DW  signed operand appended to the lane buffer
- len  in  8  elements per lane for the next run; sampled on go
- go  in  1  run request pulse
- pe_full  in  LANES  per-lane PE input-FIFO full (aff/bff of the edge PEs)
- start_out  out  1  one-cycle start pulse to the edge PEs
- vec_out  out  LANES*DW  lane i operand on bits [i*DW +: DW]
- vwe  out  LANES  per-lane write enable (awe/bwe)
- max_cntr  out  8  latched len, held stable from start_out until the next accepted go
- busy  out  1  high from go acceptance until done
- done  out  1  one-cycle pulse after the last element is issued
- go_err  out  1  one-cycle pulse when go is rejected
- ovf  out  1  sticky; set by a write to a full lane buffer

Behaviour:
- Reset:
  - state IDLE; all buffers empty (wr_ptr, rd_ptr and count are 0).
  - All outputs 0, including ovf and max_cntr.
  - Reset mid-run aborts the run immediately; done does not fire.
- Buffers:
  - One circular buffer per lane with count in 0..DEPTH.
  - A write to a full lane is dropped and sets ovf, which stays set until rst.
  - Writes are accepted in any state.
  - A write and an issue in the same lane and cycle both take effect; count is unchanged.
- go:
  - Accepted only in IDLE when 1 <= len <= DEPTH and every lane count >= len.
  - Otherwise go_err pulses the next cycle and state remains IDLE.
  - go while busy is ignored, with no go_err.
- FSM IDLE -> START -> STREAM -> DONE -> IDLE:
  - IDLE: on an accepted go, latch len into max_cntr, set busy, clear stream counter t, go to START.
  - START: start_out=1 for exactly one cycle. Latency: go at cycle n gives start_out at n+1, and lane 0's first vwe at n+2.
  - STREAM:
    - Lane i is active when i <= t < i+len.
    - An active lane drives vwe[i]=1 and vec_out lane = head entry, then pops it.
    - An inactive lane drives vwe[i]=0 and data 0.
    - Stall: if any bit of pe_full is 1 in a cycle, all vwe are 0, t holds and no lane pops. Global stall preserves the skew.
    - t increments on every non-stalled cycle. Exit to DONE after the cycle in which t = len+LANES-2 issues without stall.
  - DONE: done=1 for one cycle and busy drops in the same cycle; return to IDLE.
- pe_full is sampled combinationally in the issuing cycle. The edge PE asserts full with at least one entry of slack.
- Data is passed through unmodified (signed, DW bits); no arithmetic on operands.

Optional Feature:
- Macro FEEDER_ZERO_PAD_EN.
- Defined: during STREAM every lane drives vwe=1 on all non-stalled cycles. Lanes outside their window send data 0, so each lane delivers exactly len+LANES-1 writes, and the PE sees aligned zero padding.
- Undefined: vwe is asserted only on real elements, as described in Behaviour.

Test Plan:
- Reset: rst for 2 cycles with go held high -> all outputs 0, no start_out, busy=0.
- Basic run:
  - Setup: LANES=4; lane0 written with -1,-2,2,-2; lane1 written with -2,3,-5,-5; len=4; go at cycle n.
  - start_out at n+1; max_cntr=4.
  - Lane0 vwe at n+2..n+5 with data -1,-2,2,-2; lane1 vwe at n+3..n+6.
  - done at n+9 (t=0..6 unstalled, then DONE); all counts return to 0.
- Back-pressure: same setup with pe_full[2]=1 for 3 cycles mid-stream -> all vwe 0 for those cycles, skew between lanes unchanged, done delayed by exactly 3 cycles.
- Rejects and overflow:
  - go with len=5 while lane counts are 4 -> go_err pulse, state IDLE.
  - len=0 -> go_err.
  - 17th write to one lane (DEPTH=16) -> ovf=1, count stays 16.
- Concurrent and abort:
  - Writes to lane0 during STREAM -> new entries retained after done (count = writes).
  - rst asserted mid-STREAM -> no done, buffers empty.
- With FEEDER_ZERO_PAD_EN: len=2, LANES=4 -> each vwe high for 5 consecutive cycles. Lane3 data is 0,0,0,x0,x1, where x0 and x1 are lane3's two buffered entries.
